dsp: RTL and testbench

DSP -- requirements
Module: dsp

---
 rtl/dsp_pkg.sv | 32 +++
 rtl/dsp_pipe_reg.sv | 17 +
 rtl/dsp.sv | 52 +++++
 tb/tb_dsp.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared widths, OPERATION selector strings and per-stage pipeline payload structs
// for the dsp pre-adder / multiplier / post-adder block.
package dsp_pkg;

  localparam int AB_W   = 18;
  localparam int PROD_W = 36;
  localparam int C_W    = 48;
  localparam int P_W    = 48;

  localparam string OP_ADD = "ADD";
  localparam string OP_SUB = "SUBTRACT";

  typedef struct packed {
    logic [AB_W-1:0] a;
    logic [AB_W-1:0] b;
    logic [AB_W-1:0] d;
    logic [C_W-1:0]  c;
  } s1_t;

  typedef struct packed {
    logic [AB_W-1:0] pre;
    logic [AB_W-1:0] a;
    logic [C_W-1:0]  c;
  } s2_t;

  // Product is held zero-extended to the post-adder width.
  typedef struct packed {
    logic [P_W-1:0] prod;
    logic [C_W-1:0] c;
  } s3_t;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Generic pipeline register with synchronous active-high clear; 1 cycle latency.
// Loads every edge, no backpressure.
module dsp_pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/dsp.sv
// P = ((D op B) mod 2^18) * A + C mod 2^48 through four register stages; latency 4 cycles.
// Fully pipelined, one operation per cycle, no handshakes or backpressure.
module dsp
  import dsp_pkg::*;
#(
  parameter string OPERATION = OP_ADD
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [AB_W-1:0] A,
  input  logic [AB_W-1:0] B,
  input  logic [AB_W-1:0] D,
  input  logic [C_W-1:0]  C,
  output logic [P_W-1:0]  P
);

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;

  logic [AB_W-1:0]   pre;
  logic [PROD_W-1:0] prod;
  logic [P_W-1:0]    post;

  assign s1_d = '{a: A, b: B, d: D, c: C};

  dsp_pipe_reg #(.W($bits(s1_t))) u_s1 (.clk(clk), .clr(rstn), .d(s1_d), .q(s1_q));

  // Pre-adder wraps at 18 bits in both modes; carry and borrow are dropped.
  if (OPERATION == OP_ADD) begin : g_add
    assign pre = s1_q.d + s1_q.b;
  end else if (OPERATION == OP_SUB) begin : g_sub
    assign pre = s1_q.d - s1_q.b;
  end else begin : g_bad
    assign pre = '0;
    $error("dsp: OPERATION must be ADD or SUBTRACT");
  end

  assign s2_d = '{pre: pre, a: s1_q.a, c: s1_q.c};

  dsp_pipe_reg #(.W($bits(s2_t))) u_s2 (.clk(clk), .clr(rstn), .d(s2_d), .q(s2_q));

  assign prod = PROD_W'(s2_q.pre) * PROD_W'(s2_q.a);
  assign s3_d = '{prod: P_W'(prod), c: s2_q.c};

  dsp_pipe_reg #(.W($bits(s3_t))) u_s3 (.clk(clk), .clr(rstn), .d(s3_d), .q(s3_q));

  assign post = s3_q.prod + s3_q.c;

  dsp_pipe_reg #(.W(P_W)) u_p (.clk(clk), .clr(rstn), .d(post), .q(P));

endmodule

// File: tb/tb_dsp.sv
// Directed bench for dsp: one ADD and one SUBTRACT instance share the same stimulus.
module tb_dsp;
  import dsp_pkg::*;

  logic            clk;
  logic            rstn;
  logic [AB_W-1:0] a, b, d;
  logic [C_W-1:0]  c;
  logic [P_W-1:0]  p_add, p_sub;

  int checks = 0;
  int errors = 0;

  dsp #(.OPERATION("ADD")) u_add (
    .clk(clk), .rstn(rstn), .A(a), .B(b), .D(d), .C(c), .P(p_add)
  );

  dsp #(.OPERATION("SUBTRACT")) u_sub (
    .clk(clk), .rstn(rstn), .A(a), .B(b), .D(d), .C(c), .P(p_sub)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] ref_p(input bit sub, input logic [17:0] ra, rb, rd,
                                        input logic [47:0] rc);
    logic [17:0] rpre;
    logic [35:0] rprod;
    rpre  = sub ? rd - rb : rd + rb;
    rprod = 36'(rpre) * 36'(ra);
    return 48'(rprod) + rc;
  endfunction

  task automatic test_reset();
    rstn = 1'b1;
    a = 18'd15; b = 18'd17; d = 18'd19; c = 48'd38;
    repeat (2) @(negedge clk);
    checks++;
    if (p_add !== 48'd0) begin
      errors++; $display("FAIL reset_add got %0d want 0", p_add);
    end
    checks++;
    if (p_sub !== 48'd0) begin
      errors++; $display("FAIL reset_sub got %0d want 0", p_sub);
    end
    rstn = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (p_add !== 48'd0) begin
        errors++; $display("FAIL fill_add edge %0d got %0d want 0", k, p_add);
      end
      checks++;
      if (p_sub !== 48'd0) begin
        errors++; $display("FAIL fill_sub edge %0d got %0d want 0", k, p_sub);
      end
    end
    for (int k = 4; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (p_add !== 48'd578) begin
        errors++; $display("FAIL first_add edge %0d got %0d want 578", k, p_add);
      end
      checks++;
      if (p_sub !== 48'd68) begin
        errors++; $display("FAIL first_sub edge %0d got %0d want 68", k, p_sub);
      end
    end
  endtask

  task automatic test_wrap();
    a = 18'd2; b = 18'd1; d = 18'd0; c = 48'd0;
    repeat (4) @(negedge clk);
    checks++;
    if (p_sub !== 48'd524286) begin
      errors++; $display("FAIL sub_wrap got %0d want 524286", p_sub);
    end
    checks++;
    if (p_add !== 48'd2) begin
      errors++; $display("FAIL add_small got %0d want 2", p_add);
    end
  endtask

  task automatic test_overflow();
    a = 18'h3FFFF; b = 18'h3FFFF; d = 18'h3FFFF; c = {48{1'b1}};
    repeat (4) @(negedge clk);
    checks++;
    if (p_add !== 48'd68718690305) begin
      errors++; $display("FAIL add_overflow got %0d want 68718690305", p_add);
    end
    checks++;
    if (p_sub !== 48'hFFFF_FFFF_FFFF) begin
      errors++; $display("FAIL sub_zero_pre got %0d want %0d", p_sub, 48'hFFFF_FFFF_FFFF);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] va[15], vb[15], vd[15];
    logic [47:0] vc[15];
    for (int i = 0; i < 15; i++) begin
      va[i] = 18'($urandom_range(0, 100));
      vb[i] = 18'($urandom_range(0, 100));
      vd[i] = 18'($urandom_range(0, 100));
      vc[i] = 48'($urandom_range(0, 100));
    end
    for (int i = 0; i < 19; i++) begin
      if (i >= 4) begin
        checks++;
        if (p_add !== ref_p(1'b0, va[i-4], vb[i-4], vd[i-4], vc[i-4])) begin
          errors++;
          $display("FAIL b2b_add vec %0d got %0d want %0d", i - 4, p_add,
                   ref_p(1'b0, va[i-4], vb[i-4], vd[i-4], vc[i-4]));
        end
        checks++;
        if (p_sub !== ref_p(1'b1, va[i-4], vb[i-4], vd[i-4], vc[i-4])) begin
          errors++;
          $display("FAIL b2b_sub vec %0d got %0d want %0d", i - 4, p_sub,
                   ref_p(1'b1, va[i-4], vb[i-4], vd[i-4], vc[i-4]));
        end
      end
      if (i < 15) begin
        a = va[i]; b = vb[i]; d = vd[i]; c = vc[i];
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    a = 18'd3; b = 18'd4; d = 18'd5; c = 48'd1000;
    @(negedge clk);
    a = 18'd7; b = 18'd2; d = 18'd9; c = 48'd2000;
    @(negedge clk);
    a = 18'd11; b = 18'd1; d = 18'd6; c = 48'd3000;
    @(negedge clk);
    rstn = 1'b1;
    a = '0; b = '0; d = '0; c = '0;
    @(negedge clk);
    rstn = 1'b0;
    checks++;
    if (p_add !== 48'd0) begin
      errors++; $display("FAIL midreset_add got %0d want 0", p_add);
    end
    checks++;
    if (p_sub !== 48'd0) begin
      errors++; $display("FAIL midreset_sub got %0d want 0", p_sub);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (p_add !== 48'd0) begin
        errors++; $display("FAIL post_reset_add cycle %0d got %0d want 0", k, p_add);
      end
      checks++;
      if (p_sub !== 48'd0) begin
        errors++; $display("FAIL post_reset_sub cycle %0d got %0d want 0", k, p_sub);
      end
    end
  endtask

  initial begin
    rstn = 1'b1;
    a = '0; b = '0; d = '0; c = '0;
    @(negedge clk);
    test_reset();
    test_wrap();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
